mem_access_unit: RTL

Load/store initiator placed between the pipeline MEM stage and a multi-cycle data memory. It turns one MEM-stage load or store into a single req/ack transaction and stalls the pipeline until that transaction completes. It also performs byte/halfword lane steering, byte enables, read sign/zero extension, alignment checking and an ack timeout. It is the requesting end of the data-memory interface: the memory responds, and this block initiates.

---
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a multi-cycle data memory:
// one req/ack transaction per access, lane steering, load extension, alignment and ack timeout.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              addr_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [1:0] lane_p1;
  logic [1:0] size_p1;
  logic       uns_p1;

  logic access, illegal;
  logic latch, ack_done, timeout;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Pick the addressed byte/half from the full word and sign- or zero-extend it.
  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  assign access  = cpu_read | cpu_write;
  assign illegal = (cpu_read & cpu_write)
                 | ((cpu_size == 2'b01) & cpu_addr[0])
                 | (cpu_size[1] & (cpu_addr[1:0] != 2'b00));
  assign mem_req = (state == REQ);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    addr_err  = 1'b0;
    latch     = 1'b0;
    ack_done  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            addr_err = 1'b1;
          end else begin
            stall     = 1'b1;
            latch     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        // An ack in the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          ack_done  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: latched request fields, response capture and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      bus_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      cpu_rdata <= 32'd0;
      lane_p1   <= 2'd0;
      size_p1   <= 2'd0;
      uns_p1    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_err <= timeout;
      if (latch) begin
        cnt       <= 8'd0;
        mem_we    <= cpu_write;
        mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_be    <= lane_be(cpu_size, cpu_addr[1:0]);
        mem_wdata <= lane_wdata(cpu_size, cpu_wdata);
        lane_p1   <= cpu_addr[1:0];
        size_p1   <= cpu_size;
        uns_p1    <= cpu_unsigned;
      end else if (state == REQ) begin
        cnt <= cnt + 8'd1;
      end
      if (ack_done) begin
        cpu_rdata <= mem_we ? 32'd0 : fmt_load(mem_rdata, size_p1, lane_p1, uns_p1);
      end else if (timeout) begin
        cpu_rdata <= 32'd0;
      end
    end
  end

endmodule
